quad_rotary_decoder: RTL and testbench

Synchronous, parametrised quadrature decoder for a mechanical rotary encoder. It synchronises and debounces the raw A/B contacts, then decodes either one count per detent (x1) or every Gray-code transition (x4). Results go to an up/down position counter of configurable width, with wrap or saturate behaviour. It sits between the encoder pins and any consumer of position, step events or illegal-transition errors, all in the single system clock domain.

---
 rtl/quad_rotary_decoder.sv | 161 ++++++++++++++++
 tb/tb_quad_rotary_decoder.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/quad_rotary_decoder.sv
// ============================================================================
// Module   : quad_rotary_decoder
// Purpose  : Quadrature rotary encoder decoder with synchroniser, debounce,
//            x1/x4 decode and a wrapping or saturating up/down position count.
// Revision : 1.0
// ============================================================================
`default_nettype none

module quad_rotary_decoder #(
    parameter int CNT_W    = 8,
    parameter int DEB_CYC  = 4,
    parameter int MODE     = 0,
    parameter int SATURATE = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a,
    input  logic             b,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt,
    output logic             step,
    output logic             dir,
    output logic             err
);

    localparam int DW = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
    localparam logic [DW-1:0] C_DEB_LAST = DW'(DEB_CYC - 1);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [1:0]             init_q, init_d;
    // Channel pairs are packed as {A, B}
    logic [1:0]             s1_q, s2_q;
    logic [1:0]             filt_q, filt_d;
    logic [1:0]             prev_q, prev_d;
    logic [1:0][DW-1:0]     deb_q, deb_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   step_q, step_d;
    logic                   dir_q, dir_d;
    logic                   err_q, err_d;

    logic                   inc, dec, bad;
    logic [1:0]             pos_new, pos_old, pos_delta;

    always_comb begin
        state_d   = state_q;
        init_d    = init_q;
        filt_d    = filt_q;
        prev_d    = filt_q;
        deb_d     = deb_q;
        cnt_d     = cnt_q;
        step_d    = 1'b0;
        err_d     = 1'b0;
        dir_d     = dir_q;
        inc       = 1'b0;
        dec       = 1'b0;
        bad       = 1'b0;
        // Gray {A,B} 00,10,11,01 maps to positions 0..3 as {B, A^B}
        pos_new   = {filt_q[0], filt_q[1] ^ filt_q[0]};
        pos_old   = {prev_q[0], prev_q[1] ^ prev_q[0]};
        pos_delta = pos_new - pos_old;

        case (state_q)
            ST_INIT: begin
                // prev follows the freshly loaded level so RUN starts with no edge
                filt_d = s2_q;
                prev_d = s2_q;
                deb_d  = '0;
                init_d = init_q + 2'd1;
                if (init_q == 2'd2) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                for (int ch = 0; ch < 2; ch++) begin
                    if (s2_q[ch] != filt_q[ch]) begin
                        if (deb_q[ch] == C_DEB_LAST) begin
                            filt_d[ch] = s2_q[ch];
                            deb_d[ch]  = '0;
                        end else begin
                            deb_d[ch]  = deb_q[ch] + DW'(1);
                        end
                    end else begin
                        deb_d[ch] = '0;
                    end
                end

                if (MODE == 0) begin
                    if (!prev_q[1] && filt_q[1]) begin
                        inc = ~filt_q[0];
                        dec = filt_q[0];
                    end
                end else begin
                    inc = (pos_delta == 2'd1);
                    dec = (pos_delta == 2'd3);
                    bad = (pos_delta == 2'd2);
                end

                err_d = bad;
                if (inc || dec) begin
                    step_d = 1'b1;
                    dir_d  = inc;
                    if (inc) begin
                        if (!(SATURATE != 0 && cnt_q == {CNT_W{1'b1}})) begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end else begin
                        if (!(SATURATE != 0 && cnt_q == '0)) begin
                            cnt_d = cnt_q - CNT_W'(1);
                        end
                    end
                end
            end
            default: state_d = ST_INIT;
        endcase

        if (clr) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_INIT;
            init_q  <= 2'd0;
            s1_q    <= 2'b00;
            s2_q    <= 2'b00;
            filt_q  <= 2'b00;
            prev_q  <= 2'b00;
            deb_q   <= '0;
            cnt_q   <= '0;
            step_q  <= 1'b0;
            dir_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            init_q  <= init_d;
            s1_q    <= {a, b};
            s2_q    <= s1_q;
            filt_q  <= filt_d;
            prev_q  <= prev_d;
            deb_q   <= deb_d;
            cnt_q   <= cnt_d;
            step_q  <= step_d;
            dir_q   <= dir_d;
            err_q   <= err_d;
        end
    end

    assign cnt  = cnt_q;
    assign step = step_q;
    assign dir  = dir_q;
    assign err  = err_q;

endmodule

`default_nettype wire

// File: tb/tb_quad_rotary_decoder.sv
// Scoreboard bench: an x1/wrap decoder and an x4/saturating decoder driven
// by directed transition tables; monitors pop expected events as they occur.
`default_nettype none

module tb_quad_rotary_decoder;

    localparam logic [1:0] NO  = 2'd0;
    localparam logic [1:0] STP = 2'd1;
    localparam logic [1:0] ERR = 2'd2;

    typedef struct {
        logic       step;
        logic       err;
        logic       dir;
        logic [7:0] cnt;
        int         at;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       a1 = 1'b0, b1 = 1'b0, clr1 = 1'b0;
    logic       a4 = 1'b1, b4 = 1'b1, clr4 = 1'b0;
    logic [7:0] cnt1, cnt4;
    logic       step1, dir1, err1, step4, dir4, err4;

    int   cyc   = 0;
    int   nchk  = 0;
    int   nerr  = 0;
    exp_t q1[$];
    exp_t q4[$];
    exp_t e1, e4;
    logic [1:0] g [4];

    quad_rotary_decoder #(.CNT_W(8), .DEB_CYC(4), .MODE(0), .SATURATE(0)) u_x1 (
        .clk(clk), .rst(rst), .a(a1), .b(b1), .clr(clr1),
        .cnt(cnt1), .step(step1), .dir(dir1), .err(err1)
    );

    quad_rotary_decoder #(.CNT_W(8), .DEB_CYC(4), .MODE(1), .SATURATE(1)) u_x4 (
        .clk(clk), .rst(rst), .a(a4), .b(b4), .clr(clr4),
        .cnt(cnt4), .step(step4), .dir(dir4), .err(err4)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        nchk++;
        if (act !== expv) begin
            nerr++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, expv, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && (step1 || err1)) begin
            if (q1.size() == 0) begin
                nchk++;
                nerr++;
                $display("FAIL x1_unexpected: got step=%0b err=%0b cnt=%0d, expected no event (cycle %0d)",
                         step1, err1, cnt1, cyc);
            end else begin
                e1 = q1.pop_front();
                chk("x1_event", {21'd0, step1, err1, dir1, cnt1}, {21'd0, e1.step, e1.err, e1.dir, e1.cnt});
                chk("x1_time", cyc, e1.at);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && (step4 || err4)) begin
            if (q4.size() == 0) begin
                nchk++;
                nerr++;
                $display("FAIL x4_unexpected: got step=%0b err=%0b cnt=%0d, expected no event (cycle %0d)",
                         step4, err4, cnt4, cyc);
            end else begin
                e4 = q4.pop_front();
                chk("x4_event", {21'd0, step4, err4, dir4, cnt4}, {21'd0, e4.step, e4.err, e4.dir, e4.cnt});
                chk("x4_time", cyc, e4.at);
            end
        end
    end

    function automatic logic [12:0] E(input logic na, input logic nb, input logic [1:0] k,
                                      input logic d, input logic [7:0] c);
        return {na, nb, k, d, c};
    endfunction

    // Called just after a falling edge: the next rising edge samples the new
    // level, and the decoded event is visible seven falling edges later.
    task automatic push(input bit which, input logic [1:0] k, input logic d, input logic [7:0] c);
        exp_t t;
        t.step = (k == STP);
        t.err  = (k == ERR);
        t.dir  = d;
        t.cnt  = c;
        t.at   = cyc + 7;
        if (k != NO) begin
            if (which) q4.push_back(t);
            else       q1.push_back(t);
        end
    endtask

    task automatic apply(input bit which, input logic [12:0] v);
        push(which, v[10:9], v[8], v[7:0]);
        if (which) begin a4 = v[12]; b4 = v[11]; end
        else       begin a1 = v[12]; b1 = v[11]; end
        repeat (10) @(negedge clk);
    endtask

    initial begin
        g[0] = 2'b00; g[1] = 2'b10; g[2] = 2'b11; g[3] = 2'b01;

        repeat (3) @(negedge clk);
        chk("rst_cnt1", {24'd0, cnt1}, 32'd0);
        chk("rst_cnt4", {24'd0, cnt4}, 32'd0);
        chk("rst_flags1", {29'd0, step1, dir1, err1}, 32'd0);
        chk("rst_flags4", {29'd0, step4, dir4, err4}, 32'd0);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        chk("init_cnt4", {24'd0, cnt4}, 32'd0);

        // x4 with saturation, starting from AB=11
        apply(1, E(0, 1, STP, 1, 8'd1));
        apply(1, E(0, 0, STP, 1, 8'd2));
        apply(1, E(1, 1, ERR, 1, 8'd2));
        apply(1, E(0, 0, ERR, 1, 8'd2));
        apply(1, E(1, 0, STP, 1, 8'd3));
        apply(1, E(1, 1, STP, 1, 8'd4));
        apply(1, E(0, 1, STP, 1, 8'd5));
        apply(1, E(0, 0, STP, 1, 8'd6));
        apply(1, E(0, 1, STP, 0, 8'd5));
        apply(1, E(1, 1, STP, 0, 8'd4));
        apply(1, E(1, 0, STP, 0, 8'd3));
        apply(1, E(0, 0, STP, 0, 8'd2));
        apply(1, E(0, 1, STP, 0, 8'd1));
        apply(1, E(1, 1, STP, 0, 8'd0));
        apply(1, E(1, 0, STP, 0, 8'd0));
        apply(1, E(0, 0, STP, 0, 8'd0));
        chk("x4_sat_low", {24'd0, cnt4}, 32'd0);
        for (int i = 1; i <= 256; i++) begin
            logic [1:0] p;
            p = g[i % 4];
            apply(1, E(p[1], p[0], STP, 1, (i > 255) ? 8'd255 : 8'(i)));
        end
        chk("x4_sat_high", {24'd0, cnt4}, 32'd255);
        // Decrement coincident with clr: count clears, step still reported
        push(1, STP, 1'b0, 8'd0);
        a4 = 1'b0; b4 = 1'b1;
        repeat (6) @(negedge clk);
        clr4 = 1'b1;
        @(negedge clk);
        clr4 = 1'b0;
        repeat (4) @(negedge clk);
        chk("x4_clr", {24'd0, cnt4}, 32'd0);

        // x1 with wrap, starting from AB=00
        apply(0, E(1, 0, STP, 1, 8'd1));
        apply(0, E(0, 0, NO, 0, 8'd0));
        apply(0, E(1, 0, STP, 1, 8'd2));
        apply(0, E(0, 0, NO, 0, 8'd0));
        apply(0, E(1, 0, STP, 1, 8'd3));
        apply(0, E(0, 0, NO, 0, 8'd0));
        chk("x1_up3", {23'd0, dir1, cnt1}, {23'd0, 1'b1, 8'd3});
        apply(0, E(0, 1, NO, 0, 8'd0));
        apply(0, E(1, 1, STP, 0, 8'd2));
        chk("x1_down", {23'd0, dir1, cnt1}, {23'd0, 1'b0, 8'd2});
        apply(0, E(0, 1, NO, 0, 8'd0));
        apply(0, E(0, 0, NO, 0, 8'd0));
        // Bounce: 1,0 then settle at 1 gives exactly one increment
        a1 = 1'b1;
        @(negedge clk);
        a1 = 1'b0;
        @(negedge clk);
        push(0, STP, 1'b1, 8'd3);
        a1 = 1'b1;
        repeat (10) @(negedge clk);
        a1 = 1'b0;
        repeat (10) @(negedge clk);
        chk("x1_bounce", {24'd0, cnt1}, 32'd3);
        // Lone 3-cycle glitch never reaches the filter
        a1 = 1'b1;
        repeat (3) @(negedge clk);
        a1 = 1'b0;
        repeat (12) @(negedge clk);
        chk("x1_glitch", {24'd0, cnt1}, 32'd3);
        apply(0, E(0, 1, NO, 0, 8'd0));
        apply(0, E(1, 1, STP, 0, 8'd2));
        apply(0, E(0, 1, NO, 0, 8'd0));
        apply(0, E(1, 1, STP, 0, 8'd1));
        apply(0, E(0, 1, NO, 0, 8'd0));
        apply(0, E(1, 1, STP, 0, 8'd0));
        apply(0, E(0, 1, NO, 0, 8'd0));
        apply(0, E(1, 1, STP, 0, 8'd255));
        chk("x1_wrap_low", {24'd0, cnt1}, 32'd255);
        apply(0, E(1, 0, NO, 0, 8'd0));
        apply(0, E(0, 0, NO, 0, 8'd0));
        apply(0, E(1, 0, STP, 1, 8'd0));
        chk("x1_wrap_high", {24'd0, cnt1}, 32'd0);
        apply(0, E(0, 0, NO, 0, 8'd0));
        apply(0, E(1, 1, STP, 0, 8'd255));
        apply(0, E(0, 0, NO, 0, 8'd0));
        chk("x1_simul", {24'd0, cnt1}, 32'd255);

        repeat (5) @(negedge clk);
        chk("x1_missing", q1.size(), 32'd0);
        chk("x4_missing", q4.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

`default_nettype wire
